if_axi_bridge: RTL and testbench

Instruction-fetch bus bridge sitting directly upstream of the fetch stage. It accepts the fetch stage's valid/ready read request (address, size, read-request code), runs a single-beat AXI4 read transaction on the instruction port, and returns the fetched 64-bit beat and response code with a one-cycle ready pulse. It tolerates requests being abandoned mid-flight, for example on flush, jump or trap, without corrupting the bus protocol.

---
 rtl/if_axi_bridge_pkg.sv | 26 ++
 rtl/if_axi_bridge_if.sv | 46 ++++
 rtl/if_axi_bridge_rdata_align.sv | 11 +
 rtl/if_axi_bridge.sv | 99 +++++++++
 tb/tb_if_axi_bridge.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_axi_bridge_pkg.sv
// Shared constants for the instruction-fetch AXI bridge: request codes, AXI encodings,
// FSM state encoding and the beat-address helper.
package if_axi_bridge_pkg;

  localparam logic       REQ_READ  = 1'b0;
  localparam logic       REQ_WRITE = 1'b1;
  localparam logic [1:0] SIZE_W    = 2'b10;

  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // The instruction port is 64 bits wide, so every read targets the enclosing beat.
  function automatic logic [63:0] beatAddr(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/if_axi_bridge_if.sv
// Fetch-side request/response and AXI4 read-channel signals of the bridge.
// The master modport is the bridge's view; slave is the fetch stage plus interconnect.
interface if_axi_bridge_if #(parameter int ID_W = 4) ();

  logic            if_valid_i;
  logic [63:0]     if_addr_i;
  logic [1:0]      if_size_i;
  logic            if_req_i;
  logic            if_ready_o;
  logic [63:0]     if_data_read_o;
  logic [1:0]      if_resp_o;

  logic            ar_valid_o;
  logic            ar_ready_i;
  logic [63:0]     ar_addr_o;
  logic [ID_W-1:0] ar_id_o;
  logic [7:0]      ar_len_o;
  logic [2:0]      ar_size_o;
  logic [1:0]      ar_burst_o;

  logic            r_valid_i;
  logic            r_ready_o;
  logic [63:0]     r_data_i;
  logic [1:0]      r_resp_i;
  logic            r_last_i;
  logic [ID_W-1:0] r_id_i;

  modport master (
    input  if_valid_i, if_addr_i, if_size_i, if_req_i,
    output if_ready_o, if_data_read_o, if_resp_o,
    output ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o,
    input  ar_ready_i,
    input  r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i,
    output r_ready_o
  );

  modport slave (
    output if_valid_i, if_addr_i, if_size_i, if_req_i,
    input  if_ready_o, if_data_read_o, if_resp_o,
    input  ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o,
    output ar_ready_i,
    output r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i,
    input  r_ready_o
  );

endinterface

// File: rtl/if_axi_bridge_rdata_align.sv
// Word select for the IF_BRIDGE_ALIGN_EN build: picks the 32-bit instruction word
// addressed by bit 2 of the fetch address and zero-extends it.
module if_rdata_align (
  input  logic [63:0] i_beat,
  input  logic        i_wordSel,
  output logic [63:0] o_data
);

  assign o_data = {32'd0, (i_wordSel ? i_beat[63:32] : i_beat[31:0])};

endmodule

// File: rtl/if_axi_bridge.sv
// Instruction-fetch to AXI4 single-beat read bridge with abandon (flush/jump) tolerance.
// Optional IF_BRIDGE_ALIGN_EN: return the addressed 32-bit word instead of the raw beat.
module if_axi_bridge
  import if_axi_bridge_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  if_axi_bridge_if.master       bus
);

  logic [1:0]  r_state;
  logic [63:0] r_reqAddr;
  logic [1:0]  r_reqSize;
  logic        r_stale;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  logic        w_abandon;
  logic        w_staleNow;
  logic        w_beat;
  logic [63:0] w_beatData;

  // The fetch stage walks away by dropping valid or by presenting a different address.
  assign w_abandon  = ~bus.if_valid_i | (bus.if_addr_i != r_reqAddr);
  assign w_staleNow = r_stale | w_abandon;
  assign w_beat     = bus.r_valid_i & bus.r_last_i & (bus.r_id_i == AXI_ID);

`ifdef IF_BRIDGE_ALIGN_EN
  if_rdata_align u_align (
    .i_beat    (bus.r_data_i),
    .i_wordSel (r_reqAddr[2]),
    .o_data    (w_beatData)
  );
`else
  assign w_beatData = bus.r_data_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_reqAddr <= '0;
      r_reqSize <= '0;
      r_stale   <= 1'b0;
      r_data    <= '0;
      r_resp    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.if_valid_i && (bus.if_req_i == REQ_READ)) begin
            r_reqAddr <= bus.if_addr_i;
            r_reqSize <= bus.if_size_i;
            r_stale   <= 1'b0;
            r_state   <= ST_AR;
          end
        end
        ST_AR: begin
          r_stale <= w_staleNow;
          if (bus.ar_ready_i) r_state <= ST_R;
        end
        ST_R: begin
          r_stale <= w_staleNow;
          // Beats with a foreign ID are drained but otherwise ignored.
          if (w_beat) begin
            if (w_staleNow) begin
              r_state <= ST_IDLE;
            end else begin
              r_data  <= w_beatData;
              r_resp  <= bus.r_resp_i;
              r_state <= ST_DONE;
            end
          end
        end
        default: begin
          r_stale <= w_staleNow;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ar_valid_o     = (r_state == ST_AR);
  assign bus.ar_addr_o      = beatAddr(r_reqAddr);
  assign bus.ar_id_o        = AXI_ID;
  assign bus.ar_len_o       = 8'd0;
  assign bus.ar_size_o      = AXI_SIZE_8B;
  assign bus.ar_burst_o     = AXI_BURST_INCR;
  assign bus.r_ready_o      = (r_state == ST_R);
  assign bus.if_ready_o     = (r_state == ST_DONE) & ~r_stale & bus.if_valid_i &
                              (bus.if_addr_i == r_reqAddr);
  assign bus.if_data_read_o = r_data;
  assign bus.if_resp_o      = r_resp;

  // Fetches are always word-sized; anything else means a broken fetch stage.
  assert property (@(posedge clk) disable iff (!rst) (r_state == ST_AR) |-> (r_reqSize == SIZE_W));

endmodule

// File: tb/tb_if_axi_bridge.sv
// Directed bench for if_axi_bridge: a table of complete fetch transactions plus
// hand-written abandon, bad-ID, illegal-request and async-reset sequences.
module tb_if_axi_bridge;
  import if_axi_bridge_pkg::*;

  logic        clk;
  logic        rst;
  int          testsRun;
  int          testsFailed;
  logic [63:0] lastData;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    int          arDelay;
    int          rDelay;
    logic [63:0] expArAddr;
    logic [63:0] expRaw;
    logic [63:0] expAlign;
  } vec_t;

  vec_t vecs [5];
  vec_t extra;

  if_axi_bridge_if #(.ID_W(4)) bus ();

  if_axi_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] addr, input logic req);
    bus.if_valid_i = valid;
    bus.if_addr_i  = addr;
    bus.if_req_i   = req;
    bus.if_size_i  = SIZE_W;
  endtask

  task automatic applyBeat(input logic valid, input logic [63:0] data, input logic [1:0] resp,
                           input logic [3:0] id);
    bus.r_valid_i = valid;
    bus.r_data_i  = data;
    bus.r_resp_i  = resp;
    bus.r_last_i  = 1'b1;
    bus.r_id_i    = id;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle and walks one fetch through AR, R and DONE cycle by cycle.
  task automatic runTxn(input vec_t v);
    logic [63:0] expData;
`ifdef IF_BRIDGE_ALIGN_EN
    expData = v.expAlign;
`else
    expData = v.expRaw;
`endif
    applyStimulus(1'b1, v.addr, REQ_READ);
    bus.ar_ready_i = 1'b0;
    applyBeat(1'b0, 64'd0, 2'b00, 4'd0);
    @(negedge clk);
    checkFlag("idle_ar_valid", bus.ar_valid_o, 1'b0);
    checkFlag("idle_if_ready", bus.if_ready_o, 1'b0);
    checkOutput("idle_data_held", bus.if_data_read_o, lastData);
    nextCycle();
    for (int i = 0; i <= v.arDelay; i++) begin
      bus.ar_ready_i = (i == v.arDelay);
      @(negedge clk);
      checkFlag("ar_valid", bus.ar_valid_o, 1'b1);
      checkOutput("ar_addr", bus.ar_addr_o, v.expArAddr);
      nextCycle();
    end
    bus.ar_ready_i = 1'b0;
    for (int i = 0; i <= v.rDelay; i++) begin
      applyBeat(i == v.rDelay, v.rdata, v.rresp, 4'd0);
      @(negedge clk);
      checkFlag("r_ready", bus.r_ready_o, 1'b1);
      checkFlag("ar_valid_in_r", bus.ar_valid_o, 1'b0);
      checkFlag("if_ready_early", bus.if_ready_o, 1'b0);
      nextCycle();
    end
    applyBeat(1'b0, 64'd0, 2'b00, 4'd0);
    @(negedge clk);
    checkFlag("done_if_ready", bus.if_ready_o, 1'b1);
    checkOutput("done_data", bus.if_data_read_o, expData);
    checkOutput("done_resp", 64'(bus.if_resp_o), 64'(v.rresp));
    lastData = expData;
    nextCycle();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    lastData    = 64'd0;

    vecs[0] = '{addr: 64'h0000_0000_8000_0004, rdata: 64'h1111_2222_3333_4444, rresp: AXI_RESP_OKAY,
                arDelay: 0, rDelay: 0, expArAddr: 64'h0000_0000_8000_0000,
                expRaw: 64'h1111_2222_3333_4444, expAlign: 64'h0000_0000_1111_2222};
    vecs[1] = '{addr: 64'h0000_0000_8000_0008, rdata: 64'hAAAA_BBBB_CCCC_DDDD, rresp: AXI_RESP_OKAY,
                arDelay: 5, rDelay: 0, expArAddr: 64'h0000_0000_8000_0008,
                expRaw: 64'hAAAA_BBBB_CCCC_DDDD, expAlign: 64'h0000_0000_CCCC_DDDD};
    vecs[2] = '{addr: 64'h0000_0000_8000_1002, rdata: 64'h0123_4567_89AB_CDEF, rresp: AXI_RESP_SLVERR,
                arDelay: 0, rDelay: 2, expArAddr: 64'h0000_0000_8000_1000,
                expRaw: 64'h0123_4567_89AB_CDEF, expAlign: 64'h0000_0000_89AB_CDEF};
    vecs[3] = '{addr: 64'hFFFF_FFFF_FFFF_FFFC, rdata: 64'hDEAD_BEEF_CAFE_F00D, rresp: AXI_RESP_EXOKAY,
                arDelay: 1, rDelay: 1, expArAddr: 64'hFFFF_FFFF_FFFF_FFF8,
                expRaw: 64'hDEAD_BEEF_CAFE_F00D, expAlign: 64'h0000_0000_DEAD_BEEF};
    vecs[4] = '{addr: 64'h0000_0000_0000_0000, rdata: 64'hFEDC_BA98_7654_3210, rresp: AXI_RESP_DECERR,
                arDelay: 2, rDelay: 3, expArAddr: 64'h0000_0000_0000_0000,
                expRaw: 64'hFEDC_BA98_7654_3210, expAlign: 64'h0000_0000_7654_3210};

    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, REQ_READ);
    bus.ar_ready_i = 1'b0;
    applyBeat(1'b0, 64'd0, 2'b00, 4'd0);
    #1 rst = 1'b0;
    #2;
    checkFlag("rst_if_ready", bus.if_ready_o, 1'b0);
    checkFlag("rst_ar_valid", bus.ar_valid_o, 1'b0);
    checkFlag("rst_r_ready", bus.r_ready_o, 1'b0);
    checkOutput("rst_data", bus.if_data_read_o, 64'd0);
    checkOutput("rst_resp", 64'(bus.if_resp_o), 64'd0);
    checkOutput("rst_ar_addr", bus.ar_addr_o, 64'd0);
    #9 rst = 1'b1;
    nextCycle();

    $display("[TB] table of back-to-back fetches");
    for (int i = 0; i < 5; i++) runTxn(vecs[i]);

    $display("[TB] write request code is ignored");
    applyStimulus(1'b1, 64'h0000_0000_8000_0300, REQ_WRITE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkFlag("bad_req_no_ar", bus.ar_valid_o, 1'b0);
      nextCycle();
    end

    $display("[TB] beat with foreign ID is drained and ignored");
    applyStimulus(1'b1, 64'h0000_0000_8000_0200, REQ_READ);
    nextCycle();
    bus.ar_ready_i = 1'b1;
    nextCycle();
    bus.ar_ready_i = 1'b0;
    applyBeat(1'b1, 64'h0000_0000_DEAD_0BAD, AXI_RESP_SLVERR, 4'd5);
    @(negedge clk);
    checkFlag("badid_r_ready", bus.r_ready_o, 1'b1);
    nextCycle();
    applyBeat(1'b1, 64'h0000_0000_0000_C0DE, AXI_RESP_OKAY, 4'd0);
    @(negedge clk);
    checkFlag("badid_still_r", bus.r_ready_o, 1'b1);
    checkFlag("badid_no_ready", bus.if_ready_o, 1'b0);
    nextCycle();
    applyBeat(1'b0, 64'd0, 2'b00, 4'd0);
    @(negedge clk);
    checkFlag("badid_done", bus.if_ready_o, 1'b1);
    checkOutput("badid_data", bus.if_data_read_o, 64'h0000_0000_0000_C0DE);
    checkOutput("badid_resp", 64'(bus.if_resp_o), 64'(AXI_RESP_OKAY));
    lastData = 64'h0000_0000_0000_C0DE;
    nextCycle();

    $display("[TB] valid dropped in R, then a new fetch to 0x80000010");
    applyStimulus(1'b1, 64'h0000_0000_8000_0020, REQ_READ);
    nextCycle();
    bus.ar_ready_i = 1'b1;
    nextCycle();
    bus.ar_ready_i = 1'b0;
    applyStimulus(1'b0, 64'h0000_0000_8000_0020, REQ_READ);
    @(negedge clk);
    checkFlag("drop_r_ready", bus.r_ready_o, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 64'h0000_0000_8000_0010, REQ_READ);
    applyBeat(1'b1, 64'h0000_0000_0BAD_BEEF, AXI_RESP_OKAY, 4'd0);
    @(negedge clk);
    checkFlag("drop_no_ready", bus.if_ready_o, 1'b0);
    nextCycle();
    extra = '{addr: 64'h0000_0000_8000_0010, rdata: 64'h0000_0000_5A5A_0010, rresp: AXI_RESP_OKAY,
              arDelay: 0, rDelay: 0, expArAddr: 64'h0000_0000_8000_0010,
              expRaw: 64'h0000_0000_5A5A_0010, expAlign: 64'h0000_0000_5A5A_0010};
    runTxn(extra);

    $display("[TB] jump while AR waits");
    applyStimulus(1'b1, 64'h0000_0000_8000_0040, REQ_READ);
    nextCycle();
    bus.if_addr_i = 64'h0000_0000_8000_0100;
    @(negedge clk);
    checkOutput("jump_ar_addr_hold", bus.ar_addr_o, 64'h0000_0000_8000_0040);
    nextCycle();
    bus.ar_ready_i = 1'b1;
    @(negedge clk);
    checkFlag("jump_ar_valid_kept", bus.ar_valid_o, 1'b1);
    checkOutput("jump_ar_addr_kept", bus.ar_addr_o, 64'h0000_0000_8000_0040);
    nextCycle();
    bus.ar_ready_i = 1'b0;
    applyBeat(1'b1, 64'h0000_0000_0BAD_0040, AXI_RESP_OKAY, 4'd0);
    @(negedge clk);
    checkFlag("jump_beat_r_ready", bus.r_ready_o, 1'b1);
    nextCycle();
    extra = '{addr: 64'h0000_0000_8000_0100, rdata: 64'h0000_0000_5A5A_0100, rresp: AXI_RESP_OKAY,
              arDelay: 0, rDelay: 0, expArAddr: 64'h0000_0000_8000_0100,
              expRaw: 64'h0000_0000_5A5A_0100, expAlign: 64'h0000_0000_5A5A_0100};
    runTxn(extra);

    $display("[TB] abandon in the same cycle as the R beat");
    applyStimulus(1'b1, 64'h0000_0000_8000_0400, REQ_READ);
    nextCycle();
    bus.ar_ready_i = 1'b1;
    nextCycle();
    bus.ar_ready_i = 1'b0;
    applyStimulus(1'b0, 64'h0000_0000_8000_0400, REQ_READ);
    applyBeat(1'b1, 64'h0000_0000_0BAD_0400, AXI_RESP_OKAY, 4'd0);
    nextCycle();
    applyBeat(1'b0, 64'd0, 2'b00, 4'd0);
    @(negedge clk);
    checkFlag("same_cycle_no_ready", bus.if_ready_o, 1'b0);
    checkFlag("same_cycle_r_ready", bus.r_ready_o, 1'b0);
    checkOutput("same_cycle_data_held", bus.if_data_read_o, lastData);
    nextCycle();

    $display("[TB] stale is sticky after valid returns with the same address");
    applyStimulus(1'b1, 64'h0000_0000_8000_0500, REQ_READ);
    nextCycle();
    applyStimulus(1'b0, 64'h0000_0000_8000_0500, REQ_READ);
    nextCycle();
    applyStimulus(1'b1, 64'h0000_0000_8000_0500, REQ_READ);
    bus.ar_ready_i = 1'b1;
    nextCycle();
    bus.ar_ready_i = 1'b0;
    applyBeat(1'b1, 64'h0000_0000_0BAD_0500, AXI_RESP_OKAY, 4'd0);
    nextCycle();
    applyBeat(1'b0, 64'd0, 2'b00, 4'd0);
    @(negedge clk);
    checkFlag("sticky_no_ready", bus.if_ready_o, 1'b0);
    checkOutput("sticky_data_held", bus.if_data_read_o, lastData);
    applyStimulus(1'b0, 64'h0000_0000_8000_0500, REQ_READ);
    nextCycle();

    $display("[TB] async reset while in R");
    applyStimulus(1'b1, 64'h0000_0000_8000_0600, REQ_READ);
    nextCycle();
    bus.ar_ready_i = 1'b1;
    nextCycle();
    bus.ar_ready_i = 1'b0;
    #1;
    checkFlag("pre_rst_r_ready", bus.r_ready_o, 1'b1);
    rst = 1'b0;
    #1;
    checkFlag("mid_rst_r_ready", bus.r_ready_o, 1'b0);
    checkFlag("mid_rst_ar_valid", bus.ar_valid_o, 1'b0);
    checkFlag("mid_rst_if_ready", bus.if_ready_o, 1'b0);
    checkOutput("mid_rst_data", bus.if_data_read_o, 64'd0);
    checkOutput("mid_rst_resp", 64'(bus.if_resp_o), 64'd0);
    checkOutput("mid_rst_ar_addr", bus.ar_addr_o, 64'd0);
    lastData = 64'd0;
    applyStimulus(1'b0, 64'd0, REQ_READ);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkFlag("post_rst_r_ready", bus.r_ready_o, 1'b0);
    checkFlag("post_rst_ar_valid", bus.ar_valid_o, 1'b0);
    nextCycle();
    runTxn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
